result_checker: RTL and testbench

- Reads back the decrypted-message RAM written by the RC4 decrypter and decides whether the plaintext is plausible.
- A message is plausible only if every byte is lowercase 'a'..'z' or space.
- Sits downstream of the decrypter in the key-search loop; its pass/finish pair tells the key-search controller to stop or to try the next key.
- Read-only master on the result RAM read port; never writes.

---
 rtl/rc4_pkg.sv | 25 ++
 rtl/char_is_legal.sv | 25 ++
 rtl/result_checker.sv | 116 +++++++++++
 tb/tb_result_checker.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// +-----------------------------------------------------------------------------+
// | Module   : rc4_pkg                                                          |
// | Desc     : Shared types and character constants for the RC4 key-search.    |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
`default_nettype none

package rc4_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam byte_t LOW_CHAR   = 8'h61;
  localparam byte_t HIGH_CHAR  = 8'h7A;
  localparam byte_t SPACE_CHAR = 8'h20;

endpackage

`default_nettype wire

// File: rtl/char_is_legal.sv
// +-----------------------------------------------------------------------------+
// | Module   : char_is_legal                                                    |
// | Desc     : Combinational plausibility test for one plaintext byte.          |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
`default_nettype none

module char_is_legal #(
  parameter rc4_pkg::byte_t LOW_CHAR   = rc4_pkg::LOW_CHAR,
  parameter rc4_pkg::byte_t HIGH_CHAR  = rc4_pkg::HIGH_CHAR,
  parameter rc4_pkg::byte_t SPACE_CHAR = rc4_pkg::SPACE_CHAR
) (
  input  rc4_pkg::byte_t ch,
  output logic           legal
);

  import rc4_pkg::*;

  always_comb begin
    legal = ((ch >= LOW_CHAR) && (ch <= HIGH_CHAR)) || (ch == SPACE_CHAR);
  end

endmodule

`default_nettype wire

// File: rtl/result_checker.sv
// +-----------------------------------------------------------------------------+
// | Module   : result_checker                                                   |
// | Desc     : Scans the decrypted-message RAM and flags plausible plaintext.   |
// |            Optional macro RESULT_CHECK_ERRCNT_EN: full scan + err_count.    |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
`default_nettype none

module result_checker #(
  parameter int             DATA_WIDTH  = 8,
  parameter int             ADDR_WIDTH  = 8,
  parameter int             MESSAGE_LEN = 32,
  parameter rc4_pkg::byte_t LOW_CHAR    = rc4_pkg::LOW_CHAR,
  parameter rc4_pkg::byte_t HIGH_CHAR   = rc4_pkg::HIGH_CHAR,
  parameter rc4_pkg::byte_t SPACE_CHAR  = rc4_pkg::SPACE_CHAR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] result_addr,
  input  logic [DATA_WIDTH-1:0] result_q,
  output logic                  finish,
  output logic                  pass,
`ifdef RESULT_CHECK_ERRCNT_EN
  output logic [((MESSAGE_LEN > 1) ? $clog2(MESSAGE_LEN) : 1):0] err_count,
`endif
  output logic [ADDR_WIDTH-1:0] fail_index
);

  import rc4_pkg::*;

  localparam int             K_W    = (MESSAGE_LEN > 1) ? $clog2(MESSAGE_LEN) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(MESSAGE_LEN - 1);

  state_e         r_state;
  logic [K_W-1:0] r_k;
  logic [K_W-1:0] w_k_next;
  logic           w_legal;

  char_is_legal #(
    .LOW_CHAR   (LOW_CHAR),
    .HIGH_CHAR  (HIGH_CHAR),
    .SPACE_CHAR (SPACE_CHAR)
  ) u_char_is_legal (
    .ch    (result_q),
    .legal (w_legal)
  );

  // Only used below K_LAST, so the increment never wraps.
  always_comb begin
    w_k_next = r_k + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_k         <= '0;
      result_addr <= '0;
      finish      <= 1'b0;
      pass        <= 1'b0;
      fail_index  <= '0;
`ifdef RESULT_CHECK_ERRCNT_EN
      err_count   <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_k         <= '0;
            result_addr <= '0;
            r_state     <= WAIT;
          end
        end
        // One wait state covers the registered RAM read.
        WAIT: r_state <= CHECK;
        CHECK: begin
`ifdef RESULT_CHECK_ERRCNT_EN
          if (!w_legal) begin
            err_count <= err_count + 1'b1;
            if (err_count == '0) fail_index <= ADDR_WIDTH'(r_k);
          end
          if (r_k == K_LAST) begin
            pass    <= w_legal && (err_count == '0);
            finish  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_k         <= w_k_next;
            result_addr <= ADDR_WIDTH'(w_k_next);
            r_state     <= WAIT;
          end
`else
          if (!w_legal) begin
            fail_index <= ADDR_WIDTH'(r_k);
            pass       <= 1'b0;
            finish     <= 1'b1;
            r_state    <= DONE;
          end else if (r_k == K_LAST) begin
            pass    <= 1'b1;
            finish  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_k         <= w_k_next;
            result_addr <= ADDR_WIDTH'(w_k_next);
            r_state     <= WAIT;
          end
`endif
        end
        DONE: r_state <= DONE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_result_checker.sv
// +-----------------------------------------------------------------------------+
// | Module   : tb_result_checker                                                |
// | Desc     : Directed self-checking bench for result_checker.                 |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_result_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] result_addr;
  logic [7:0] result_q;
  logic       finish;
  logic       pass;
  logic [7:0] fail_index;
`ifdef RESULT_CHECK_ERRCNT_EN
  logic [5:0] err_count;
`endif

  logic [7:0] mem [0:255];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Registered read port: one wait state between address and data use.
  always @(posedge clk) result_q <= mem[result_addr];

  result_checker dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .result_addr (result_addr),
    .result_q    (result_q),
    .finish      (finish),
    .pass        (pass),
`ifdef RESULT_CHECK_ERRCNT_EN
    .err_count   (err_count),
`endif
    .fail_index  (fail_index)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; start = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic fill(input logic [7:0] c);
    for (int i = 0; i < 256; i++) mem[i] = c;
  endtask

  task automatic run_scan(input bit hold, output int lat, output int maxa,
                          output logic [31:0] seen, output bit quiet);
    lat = -1; maxa = 0; seen = '0; quiet = 1'b1;
    @(negedge clk); start = 1'b1;
    for (int e = 0; e < 200; e++) begin
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      if (int'(result_addr) > maxa) maxa = int'(result_addr);
      if (result_addr < 8'd32) seen[result_addr[4:0]] = 1'b1;
      if (finish) begin lat = e; break; end
      if (pass !== 1'b0 || fail_index !== 8'd0) quiet = 1'b0;
    end
    if (lat < 0) chk("scan_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int          lat, maxa;
    logic [31:0] seen;
    bit          quiet, stable;
    string       msg;
    logic [7:0]  snap_addr, snap_fi;
    logic        snap_pass, snap_fin;
    logic [7:0]  bchar  [6];
    bit          blegal [6];

    rst = 1'b1; start = 1'b0;
    fill(8'h61);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("rst_finish", finish, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail_index", fail_index, 0);
    chk("rst_addr", result_addr, 0);
`ifdef RESULT_CHECK_ERRCNT_EN
    chk("rst_err_count", err_count, 0);
`endif

    // Plausible message, padded with spaces.
    msg = "attack at dawn";
    fill(8'h20);
    for (int i = 0; i < msg.len(); i++) mem[i] = msg[i];
    run_scan(1'b0, lat, maxa, seen, quiet);
    chk("attack_latency", lat, 64);
    chk("attack_pass", pass, 1);
    chk("attack_fail_index", fail_index, 0);
    chk("attack_addr_sweep", seen, 32'hFFFF_FFFF);
    chk("attack_max_addr", maxa, 31);
    chk("attack_quiet_before_finish", quiet, 1);

    // Uppercase at index 5, start held high afterwards.
    do_reset();
    fill(8'h61); mem[5] = 8'h41;
    run_scan(1'b1, lat, maxa, seen, quiet);
`ifdef RESULT_CHECK_ERRCNT_EN
    chk("bad5_latency", lat, 64);
    chk("bad5_max_addr", maxa, 31);
`else
    chk("bad5_latency", lat, 12);
    chk("bad5_max_addr", maxa, 5);
`endif
    chk("bad5_pass", pass, 0);
    chk("bad5_fail_index", fail_index, 5);

    snap_addr = result_addr; snap_fi = fail_index;
    snap_pass = pass;        snap_fin = finish;
    stable = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (result_addr !== snap_addr || fail_index !== snap_fi ||
          pass !== snap_pass || finish !== snap_fin) stable = 1'b0;
    end
    chk("done_hold_stable", stable, 1);
    chk("done_hold_finish", finish, 1);
    start = 1'b0;

    // Boundary characters at index 0.
    bchar  = '{8'h60, 8'h7B, 8'h1F, 8'h61, 8'h7A, 8'h20};
    blegal = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int b = 0; b < 6; b++) begin
      do_reset();
      fill(8'h61); mem[0] = bchar[b];
      run_scan(1'b0, lat, maxa, seen, quiet);
      chk($sformatf("edge_%02h_pass", bchar[b]), pass, {31'd0, blegal[b]});
      chk($sformatf("edge_%02h_fail_index", bchar[b]), fail_index, 0);
`ifdef RESULT_CHECK_ERRCNT_EN
      chk($sformatf("edge_%02h_latency", bchar[b]), lat, 64);
`else
      chk($sformatf("edge_%02h_latency", bchar[b]), lat, blegal[b] ? 64 : 2);
`endif
    end

    // Reset at edge 20 of a valid scan, then a fresh scan.
    do_reset();
    fill(8'h61);
    @(negedge clk); start = 1'b1;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_finish", finish, 0);
    chk("midrst_pass", pass, 0);
    chk("midrst_fail_index", fail_index, 0);
    chk("midrst_addr", result_addr, 0);
    run_scan(1'b0, lat, maxa, seen, quiet);
    chk("midrst_rescan_latency", lat, 64);
    chk("midrst_rescan_pass", pass, 1);

`ifdef RESULT_CHECK_ERRCNT_EN
    do_reset();
    fill(8'h61); mem[3] = 8'h41; mem[9] = 8'h41; mem[31] = 8'h41;
    run_scan(1'b0, lat, maxa, seen, quiet);
    chk("errcnt_latency", lat, 64);
    chk("errcnt_count", err_count, 3);
    chk("errcnt_fail_index", fail_index, 3);
    chk("errcnt_pass", pass, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
